// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit path among N_REQ requesters.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a transfer whose done never returns.
module uart_tx_arbiter #(
  parameter int NB_DATA        = 32,
  parameter int N_REQ          = 4,
  parameter int NB_TIMEOUT     = 18,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_req_32b,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  input  logic                     i_tx_done_8b,
  input  logic                     i_tx_done_32b,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start_8b,
  output logic                     o_tx_start_32b,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_done,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int NB_IDX = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RELEASE} state_t;

  state_t              state_reg, state_next;
  logic [NB_IDX-1:0]   ptr_reg, ptr_next;
  logic [NB_IDX-1:0]   g_reg, g_next;
  logic                size_reg, size_next;
  logic [NB_DATA-1:0]  data_reg, data_next;
  logic                start_8b_reg, start_8b_next;
  logic                start_32b_reg, start_32b_next;
  logic [N_REQ-1:0]    grant_reg, grant_next;
  logic [N_REQ-1:0]    done_reg, done_next;
  logic                busy_reg, busy_next;

  logic                arb_found;
  logic [NB_IDX-1:0]   arb_idx;
  logic                xfer_done;
  logic                wd_hit;

  logic [NB_DATA-1:0]  req_data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_data_arr[gi] = i_req_data[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

  // Two passes: first set bit at or above ptr, otherwise wrap to the lowest set bit.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!arb_found && i_req[j] && (NB_IDX'(j) >= ptr_reg)) begin
        arb_found = 1'b1;
        arb_idx   = NB_IDX'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!arb_found && i_req[j]) begin
        arb_found = 1'b1;
        arb_idx   = NB_IDX'(j);
      end
    end
  end

  // A word transfer ignores the UART's per-byte done pulses.
  assign xfer_done = size_reg ? i_tx_done_32b : i_tx_done_8b;

`ifdef UART_ARB_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] wd_cnt_reg, wd_cnt_next;
  logic                  timeout_reg, timeout_next;

  assign wd_hit = (state_reg == ST_WAIT) && (wd_cnt_reg == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_next  = '0;
    timeout_next = 1'b0;
    if (state_reg == ST_WAIT) begin
      wd_cnt_next  = wd_cnt_reg + 1'b1;
      timeout_next = wd_hit && !xfer_done;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    g_next         = g_reg;
    size_next      = size_reg;
    data_next      = data_reg;
    start_8b_next  = 1'b0;
    start_32b_next = 1'b0;
    grant_next     = grant_reg;
    done_next      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_found) begin
          g_next         = arb_idx;
          size_next      = i_req_32b[arb_idx];
          data_next      = req_data_arr[arb_idx];
          grant_next     = ONE_HOT0 << arb_idx;
          start_32b_next = i_req_32b[arb_idx];
          start_8b_next  = !i_req_32b[arb_idx];
          state_next     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (xfer_done || wd_hit) begin
          done_next  = ONE_HOT0 << g_reg;
          grant_next = '0;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        ptr_next   = (g_reg == NB_IDX'(N_REQ - 1)) ? '0 : g_reg + 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      g_reg         <= '0;
      size_reg      <= 1'b0;
      data_reg      <= '0;
      start_8b_reg  <= 1'b0;
      start_32b_reg <= 1'b0;
      grant_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      g_reg         <= g_next;
      size_reg      <= size_next;
      data_reg      <= data_next;
      start_8b_reg  <= start_8b_next;
      start_32b_reg <= start_32b_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign o_tx_data      = data_reg;
  assign o_tx_start_8b  = start_8b_reg;
  assign o_tx_start_32b = start_32b_reg;
  assign o_grant        = grant_reg;
  assign o_done         = done_reg;
  assign o_busy         = busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by randomized traffic
// checked against a round-robin reference model (watchdog scenario only with UART_ARB_TIMEOUT_EN).
module tb_uart_tx_arbiter;
  localparam int NB_DATA        = 32;
  localparam int N_REQ          = 4;
  localparam int NB_TIMEOUT     = 18;
  localparam int TIMEOUT_CYCLES = 100;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic [N_REQ-1:0]         req = '0;
  logic [N_REQ-1:0]         req_32b = '0;
  logic [N_REQ*NB_DATA-1:0] req_data = '0;
  logic                     tx_done_8b = 1'b0;
  logic                     tx_done_32b = 1'b0;
  logic [NB_DATA-1:0]       tx_data;
  logic                     tx_start_8b;
  logic                     tx_start_32b;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic                     busy;
  logic                     timeout;

  int n_tests = 0;
  int n_fail = 0;
  int model_ptr = 0;

  uart_tx_arbiter #(
    .NB_DATA(NB_DATA), .N_REQ(N_REQ), .NB_TIMEOUT(NB_TIMEOUT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clock(clock), .i_reset_n(reset_n), .i_req(req), .i_req_32b(req_32b),
    .i_req_data(req_data), .i_tx_done_8b(tx_done_8b), .i_tx_done_32b(tx_done_32b),
    .o_tx_data(tx_data), .o_tx_start_8b(tx_start_8b), .o_tx_start_32b(tx_start_32b),
    .o_grant(grant), .o_done(done), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_starts"}, {tx_start_8b, tx_start_32b}, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // Reference: owner is the first pending requester at or after model_ptr, modulo N_REQ.
  function automatic int pick_owner();
    int owner;
    owner = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = (model_ptr + k) % N_REQ;
      if (owner < 0 && req[c]) owner = c;
    end
    return owner;
  endfunction

  // One full transaction; DUT must be in IDLE with at least one request pending.
  task automatic serve(input int wait_cycles, input int n_spur, input bit clobber);
    int          g;
    logic [31:0] exp_data;
    bit          exp_sz;
    logic [3:0]  exp_oh;
    g = pick_owner();
    if (g < 0) g = 0;
    exp_data = req_data[g*NB_DATA +: NB_DATA];
    exp_sz   = req_32b[g];
    exp_oh   = 4'b0001 << g;
    tick();
    check("grant", grant, exp_oh);
    check("start_8b", tx_start_8b, !exp_sz);
    check("start_32b", tx_start_32b, exp_sz);
    check("tx_data", tx_data, exp_data);
    check("busy", busy, 1);
    tick();
    check("start_clear", {tx_start_8b, tx_start_32b}, 0);
    if (clobber) begin
      req_data = '0;
      req_32b  = ~req_32b;
    end
    for (int i = 0; i < wait_cycles; i++) begin
      if (exp_sz && i < n_spur) tx_done_8b = 1'b1;
      tick();
      tx_done_8b = 1'b0;
      check("grant_hold", grant, exp_oh);
    end
    check("no_early_done", done, 0);
    if (exp_sz) tx_done_32b = 1'b1;
    else tx_done_8b = 1'b1;
    tick();
    tx_done_8b  = 1'b0;
    tx_done_32b = 1'b0;
    check("done", done, exp_oh);
    check("grant_clear", grant, 0);
    check("timeout_quiet", timeout, 0);
    check("data_held", tx_data, exp_data);
    req[g]    = 1'b0;
    model_ptr = (g + 1) % N_REQ;
    tick();
    check("done_single", done, 0);
    check("busy_clear", busy, 0);
    $display("[TB] xfer owner=%0d size=%s data=%08h wait=%0d spur=%0d clobber=%0d",
             g, exp_sz ? "word" : "byte", exp_data, wait_cycles, n_spur, clobber);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Byte transfer: done sampled at edge 40, completion visible at cycle 41
    req_data[31:0] = 32'h123456A5;
    req_32b        = 4'b0000;
    req            = 4'b0001;
    serve(38, 0, 0);

    // Word transfer: three byte-done pulses ignored, then word done
    req_data[95:64] = 32'hDEADBEEF;
    req_32b[2]      = 1'b1;
    req             = 4'b0100;
    serve(6, 3, 0);

    // Round-robin from a fresh reset
    reset_n = 1'b0;
    tick();
    reset_n   = 1'b1;
    model_ptr = 0;
    for (int k = 0; k < N_REQ; k++) req_data[k*NB_DATA +: NB_DATA] = $urandom;
    req_32b = 4'($urandom);
    req     = 4'b1111;
    for (int k = 0; k < N_REQ; k++) serve(2, 1, 0);
    req = 4'b0011;
    serve(1, 0, 0);
    serve(1, 0, 0);
    req = 4'b0101;
    serve(1, 0, 0);
    serve(1, 0, 0);

    // Latch isolation: data and size overwritten during WAIT
    req_data[127:96] = 32'hCAFE0042;
    req_32b          = 4'b0000;
    req              = 4'b1000;
    serve(5, 0, 1);

    // Reset mid-WAIT
    req_data[63:32] = 32'h55AA33CC;
    req_32b         = 4'b0010;
    req             = 4'b0010;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    check("midreset_no_done", done, 0);
    reset_n   = 1'b1;
    model_ptr = 0;
    req       = 4'b1011;
    serve(1, 0, 0);
    check("after_reset_owner0_first", model_ptr, 1);
    serve(1, 0, 0);
    serve(1, 0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no done returned; abort 100 cycles after WAIT entry
    req_32b = 4'b0100;
    req     = 4'b0100;
    tick();
    check("wd_grant", grant, 4'b0100);
    tick();
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    check("wd_no_early_done", done, 0);
    tick();
    check("wd_timeout", timeout, 1);
    check("wd_done", done, 4'b0100);
    check("wd_grant_clear", grant, 0);
    req[2]    = 1'b0;
    model_ptr = 3;
    tick();
    check("wd_timeout_single", timeout, 0);
    check("wd_busy_clear", busy, 0);
    $display("[TB] watchdog owner=2 timeout after %0d cycles", TIMEOUT_CYCLES);
    req = 4'b1001;
    serve(1, 0, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      req = req | 4'($urandom_range(1, 15));
      for (int k = 0; k < N_REQ; k++) req_data[k*NB_DATA +: NB_DATA] = $urandom;
      req_32b = 4'($urandom);
      serve(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < N_REQ && req != 0; n++) serve(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer sharing the single transmit path of the 32-bit UART among `N_REQ` requesters (debug unit, register dump, status reporter, and similar). It grants one requester at a time and latches that requester's word and size. It then issues exactly one start pulse (8-bit or 32-bit) to the UART and holds the grant until the matching done pulse returns, then signals completion to the owner. It sits between the requesters and the UART's `i_tx_data`/`i_tx_start_*`/`o_tx_done_*` ports.

## Interface
- `NB_DATA`, 32, transfer word width
- `N_REQ`, 4, number of requesters (≥2)
- `NB_TIMEOUT`, 18, width of watchdog counter
- `TIMEOUT_CYCLES`, 200000, watchdog limit in clocks (only used with the macro)

Ports:
- `i_clock` in 1: single clock
- `i_reset_n` in 1: reset, asynchronous, active-low
- `i_req` in `N_REQ`: level request per requester, held until its `o_done`
- `i_req_32b` in `N_REQ`: per-requester size, 1 = 32-bit word, 0 = byte `[7:0]`
- `i_req_data` in `N_REQ*NB_DATA`: flattened data, requester k at `[k*NB_DATA +: NB_DATA]`
- `i_tx_done_8b` in 1: UART byte-done pulse
- `i_tx_done_32b` in 1: UART word-done pulse
- `o_tx_data` out `NB_DATA`: word to UART
- `o_tx_start_8b` out 1: one-cycle start pulse, byte transfer
- `o_tx_start_32b` out 1: one-cycle start pulse, word transfer
- `o_grant` out `N_REQ`: one-hot owner, zero when no transfer is active
- `o_done` out `N_REQ`: one-cycle completion pulse to the owner
- `o_busy` out 1: high in any state other than IDLE
- `o_timeout` out 1: one-cycle watchdog pulse, tied 0 without the macro

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RELEASE. All outputs are registered.
- IDLE:
  - If any `i_req` is set, select the first set bit scanning from `ptr` upward, wrapping modulo `N_REQ`.
  - Latch the index `g`, `i_req_data` slice into `o_tx_data`, and `i_req_32b[g]` into size.
  - Set `o_grant[g]` and go to LAUNCH.
- LAUNCH: assert `o_tx_start_32b` if size = 1, else `o_tx_start_8b`, for exactly this cycle. Go to WAIT.
- WAIT:
  - Size 0: finish on `i_tx_done_8b`.
  - Size 1: finish only on `i_tx_done_32b`. Intermediate `i_tx_done_8b` pulses are ignored.
  - On finish, go to RELEASE.
- RELEASE:
  - `o_done[g]` = 1 for one cycle and `o_grant` = 0.
  - `ptr` ← (g+1) mod `N_REQ`. No arbitration this cycle.
  - Next state is IDLE.
- Requester data and size changes after the grant are ignored. `o_tx_data` holds its value until the next grant.
- Done pulses arriving in IDLE, LAUNCH or RELEASE are ignored.
- Requesters drop `i_req` on the cycle after seeing `o_done`. A request still high in IDLE is treated as a new request.
- Reset values: state IDLE, `ptr` 0, and all outputs 0, including `o_tx_data`.
- Asserting reset mid-transfer returns to IDLE asynchronously with no `o_done`. The UART shares the reset.

## Timing
- Request seen in IDLE at cycle 0:
  - `o_grant` and `o_busy` go high at cycle 1.
  - The start pulse occurs at cycle 1 (LAUNCH).
  - WAIT begins at cycle 2.
- Done pulse sampled at cycle t in WAIT: `o_done` pulses and `o_grant` clears at t+1. IDLE is at t+2.
- Minimum back-to-back spacing between start pulses: 4 cycles plus UART transfer time.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches `TIMEOUT_CYCLES-1` without the expected done, the FSM enters RELEASE.
  - In that RELEASE cycle, `o_timeout` pulses together with `o_done[g]`, and `ptr` advances normally.
- Undefined: the counter is not built, WAIT waits indefinitely, and `o_timeout` is constant 0.

## Test plan
- Byte transfer:
  - Stimulus: `i_req`=0001, `i_req_32b`=0, data 0x123456A5; inject `i_tx_done_8b` at cycle 40.
  - Response: `o_grant`=0001 and `o_tx_start_8b` pulse at cycle 1, `o_tx_data`=0x123456A5, `o_done`=0001 at 41, `o_grant`=0 at 41.
- Word transfer:
  - Stimulus: requester 2, size 1, data 0xDEADBEEF; three `i_tx_done_8b` pulses, then `i_tx_done_32b`.
  - Response: a single `o_tx_start_32b` pulse, and `o_done`=0100 only after `i_tx_done_32b`.
- Round-robin:
  - Stimulus: all four requests asserted after reset.
  - Response: grants in order 0,1,2,3.
  - Follow-up: after granting 1, requests 0 and 2 pending → 2 is granted before 0.
- Latch isolation: change requester data to 0x0 during WAIT → `o_tx_data` stays at the latched value.
- Reset mid-WAIT: `i_reset_n` low → all outputs 0 immediately, no `o_done`. A new request after release is granted to requester 0 first.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: no done is returned → `o_timeout` and `o_done[g]` pulse 100 cycles after WAIT entry, then the next requester is served.
